// File: rtl/cache_mem_backend.sv
// Main-memory stage behind the cache: serves line refills as bursts and
// write-through stores after a fixed access latency, one request at a time.
module cache_mem_backend #(
  parameter int unsigned LATENCY    = 4,   // 1..15
  parameter int unsigned LINE_WORDS = 1,   // 1, 2 or 4
  parameter int unsigned DEPTH      = 256  // power of 2, <= 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        wdone,
  output logic        errAddr
);

  localparam int unsigned   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS - 1);
  localparam logic [3:0]    LAT_LOAD  = 4'(LATENCY - 1);
  localparam logic [2:0]    BEATS     = 3'(LINE_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_WCOMMIT} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;
  typedef logic [31:0] mem_t [DEPTH];

  // Power-up image shared with the cache: word i holds i*5.
  function automatic mem_t mem_image();
    mem_t img;
    for (int unsigned i = 0; i < DEPTH; i++) img[i] = 32'(i * 5);
    return img;
  endfunction

  // Storage is preset once at time zero and deliberately untouched by reset.
  mem_t mem_q = mem_image();

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    beat_q, beat_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          wdone_q, wdone_d;
  logic          err_q, err_d;
  logic          mem_we;

  logic [AW-1:0] addr_idx;
  logic          addr_oob;

  assign addr_idx = addr[AW-1:0];
  assign addr_oob = |addr[31:AW];

  // Next-state and registered-output logic for the request FSM.
  // The store commit and the first refill beat are both produced on the
  // edge that leaves WAIT, so data/commit appear exactly LATENCY edges
  // after the accept; WCOMMIT and the tail of BURST only close the request.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    wdone_d  = 1'b0;
    err_d    = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (memRead || memWrite) begin
          if (addr_oob) begin
            err_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            busy_d  = 1'b1;
            cnt_d   = LAT_LOAD;
            beat_d  = '0;
            if (memRead) begin
              op_d  = OP_READ;
              idx_d = addr_idx & ~LINE_MASK;
            end else begin
              op_d    = OP_WRITE;
              idx_d   = addr_idx;
              wdata_d = wdata;
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (op_q == OP_READ) begin
            state_d  = S_BURST;
            rvalid_d = 1'b1;
            rdata_d  = mem_q[idx_q];
            beat_d   = 3'd1;
          end else begin
            state_d = S_WCOMMIT;
            mem_we  = 1'b1;
            wdone_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_BURST: begin
        if (beat_q == BEATS) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = mem_q[idx_q + AW'(beat_q)];
          beat_d   = beat_q + 3'd1;
        end
      end
      S_WCOMMIT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_READ;
      cnt_q    <= '0;
      beat_q   <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      wdone_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      wdone_q  <= wdone_d;
      err_q    <= err_d;
    end
  end

  // Word store write port; no reset so committed data survives a reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign busy    = busy_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign wdone   = wdone_q;
  assign errAddr = err_q;

endmodule

// File: tb/tb_cache_mem_backend.sv
// Bench for cache_mem_backend: two instances (1-word and 4-word lines) see
// the same request stream and are compared cycle by cycle with a reference.
module tb_cache_mem_backend;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite;
  logic [31:0] addr, wdata;

  logic        a_busy, a_rvalid, a_wdone, a_err;
  logic [31:0] a_rdata;
  logic        b_busy, b_rvalid, b_wdone, b_err;
  logic [31:0] b_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] last_a, last_b;

  always #5 clk = ~clk;

  cache_mem_backend #(.LATENCY(L), .LINE_WORDS(1), .DEPTH(256)) u_l1 (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .wdata(wdata), .busy(a_busy), .rdata(a_rdata),
    .rvalid(a_rvalid), .wdone(a_wdone), .errAddr(a_err)
  );

  cache_mem_backend #(.LATENCY(L), .LINE_WORDS(4), .DEPTH(256)) u_l4 (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .wdata(wdata), .busy(b_busy), .rdata(b_rdata),
    .rvalid(b_rvalid), .wdone(b_wdone), .errAddr(b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " L1 busy"},   32'(a_busy),   32'd0);
    check({tag, " L1 rvalid"}, 32'(a_rvalid), 32'd0);
    check({tag, " L1 wdone"},  32'(a_wdone),  32'd0);
    check({tag, " L1 err"},    32'(a_err),    32'd0);
    check({tag, " L1 rdata"},  a_rdata,       32'd0);
    check({tag, " L4 busy"},   32'(b_busy),   32'd0);
    check({tag, " L4 rvalid"}, 32'(b_rvalid), 32'd0);
    check({tag, " L4 wdone"},  32'(b_wdone),  32'd0);
    check({tag, " L4 err"},    32'(b_err),    32'd0);
    check({tag, " L4 rdata"},  b_rdata,       32'd0);
  endtask

  // kind: 0 read, 1 write, 2 rejected; n = edges after the accept edge.
  task automatic check_inst(input string nm, input int lw, input int kind,
                            input logic [7:0] a_idx, input int n,
                            input logic busy_o, input logic rvalid_o,
                            input logic [31:0] rdata_o, input logic wdone_o,
                            input logic err_o, inout logic [31:0] last);
    logic       eb, erv, ewd, eer;
    logic [7:0] base;
    eb = 1'b0; erv = 1'b0; ewd = 1'b0; eer = 1'b0;
    base = a_idx & ~8'(lw - 1);
    case (kind)
      0: begin
        eb = (n < L + lw);
        if (n >= L && n < L + lw) begin
          erv  = 1'b1;
          last = ref_mem[8'(base + 8'(n - L))];
        end
      end
      1: begin
        eb  = (n < L + 1);
        ewd = (n == L);
      end
      default: eer = (n == 0);
    endcase
    check($sformatf("%s busy n=%0d", nm, n),   32'(busy_o),   32'(eb));
    check($sformatf("%s rvalid n=%0d", nm, n), 32'(rvalid_o), 32'(erv));
    check($sformatf("%s rdata n=%0d", nm, n),  rdata_o,       last);
    check($sformatf("%s wdone n=%0d", nm, n),  32'(wdone_o),  32'(ewd));
    check($sformatf("%s errAddr n=%0d", nm, n), 32'(err_o),   32'(eer));
  endtask

  task automatic clear_inputs();
    memRead = 1'b0; memWrite = 1'b0; addr = '0; wdata = '0;
  endtask

  // One request; abort_at >= 0 asserts reset after that many edges.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int abort_at);
    int kind;
    bit aborted;
    aborted = 1'b0;
    kind = (a[31:8] != 0) ? 2 : (rd ? 0 : 1);
    @(negedge clk);
    memRead = rd; memWrite = wr; addr = a; wdata = d;
    for (int n = 0; n <= L + 4; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_inst("L1", 1, kind, a[7:0], n, a_busy, a_rvalid, a_rdata, a_wdone, a_err, last_a);
      check_inst("L4", 4, kind, a[7:0], n, b_busy, b_rvalid, b_rdata, b_wdone, b_err, last_b);
      if (n == abort_at) begin
        clear_inputs();
        reset = 1'b1;
        #1;
        check_zero("abort");
        last_a = '0;
        last_b = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (n <= L && kind != 2) begin
        // Noise while busy must be ignored by both instances.
        memRead  = 1'($urandom);
        memWrite = 1'($urandom);
        addr     = ($urandom % 2 == 0) ? $urandom : ($urandom % 256);
        wdata    = $urandom;
      end else begin
        clear_inputs();
      end
    end
    clear_inputs();
    if (kind == 1 && (!aborted || abort_at >= L)) ref_mem[a[7:0]] = d;
  endtask

  initial begin
    logic [31:0] ra;
    int op;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i) * 32'd5;
    last_a = '0;
    last_b = '0;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    run_txn(1'b1, 1'b0, 32'd10, 32'd0, -1);          // 50 / 40..55
    run_txn(1'b1, 1'b0, 32'd6, 32'd0, -1);           // 30 / 20..35
    run_txn(1'b0, 1'b1, 32'd3, 32'hDEADBEEF, -1);
    run_txn(1'b1, 1'b0, 32'd3, 32'd0, -1);
    run_txn(1'b1, 1'b1, 32'd2, 32'h12345678, -1);    // read wins
    run_txn(1'b1, 1'b0, 32'd2, 32'd0, -1);
    run_txn(1'b1, 1'b0, 32'h100, 32'd0, -1);         // rejected
    run_txn(1'b0, 1'b1, 32'h105, 32'h00000BAD, -1);  // rejected, no wrap write
    run_txn(1'b1, 1'b0, 32'd5, 32'd0, -1);
    run_txn(1'b0, 1'b1, 32'd5, 32'd7, 2);            // reset inside WAIT
    run_txn(1'b1, 1'b0, 32'd5, 32'd0, -1);           // still 25
    run_txn(1'b0, 1'b1, 32'd9, 32'h0000_1234, L);    // reset after commit
    run_txn(1'b1, 1'b0, 32'd9, 32'd0, -1);
    run_txn(1'b1, 1'b0, 32'd255, 32'd0, -1);         // top line

    for (int t = 0; t < 80; t++) begin
      op = int'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) begin
        ra = $urandom;
        if (ra[31:8] == 0) ra[31] = 1'b1;
      end else begin
        ra = $urandom_range(0, 255);
      end
      run_txn(op[0], op[1], ra, $urandom, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
